// File: rtl/c2h_stream_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// c2h_arb_pkg
// Shared definitions for the C2H stream arbiter:
//   ST_IDLE / ST_XFER   arbiter FSM state encoding
//   DEFAULT_N_SRC       default number of requesting streams
//   DEFAULT_DATA_WIDTH  default tdata width
//   MAX_SRC             largest supported N_SRC (sizes the rr_next request vector)
//   rr_next()           round-robin pick: first requester after last_ptr
// ---------------------------------------------------------------------------
package c2h_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_XFER = 1'b1;

  localparam int DEFAULT_N_SRC      = 4;
  localparam int DEFAULT_DATA_WIDTH = 256;
  localparam int MAX_SRC            = 8;

  // Search starts at (last_ptr + 1) mod n_src and wraps, so the source
  // served last has the lowest priority. Returns last_ptr when nothing
  // requests; callers only use the result when some request is present.
  function automatic logic [2:0] rr_next(input logic [MAX_SRC-1:0] req,
                                         input logic [2:0]         last_ptr,
                                         input int                 n_src);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last_ptr;
    found = 1'b0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      idx = (int'(last_ptr) + k) % n_src;
      if ((k <= n_src) && !found && req[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/c2h_stream_arbiter_slice.sv
// ---------------------------------------------------------------------------
// axis_reg_slice
// Two-entry skid buffer for an AXI-Stream (tdata, tkeep, tlast). Every
// output is driven straight from a flop; in_ready is also a flop output
// (it is low only while the skid entry is occupied).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_*         upstream stream
//   out_valid/out_ready/out_*      downstream stream (registered)
// ---------------------------------------------------------------------------
module axis_reg_slice #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_W-1:0]     in_keep,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_W-1:0]     out_keep,
  output logic                  out_last
);

  localparam int PW = DATA_WIDTH + KEEP_W + 1;

  logic [PW-1:0] main_q;
  logic          main_valid_q;
  logic [PW-1:0] skid_q;
  logic          skid_valid_q;
  logic [PW-1:0] in_payload;

  assign in_payload = {in_last, in_keep, in_data};
  assign in_ready   = !skid_valid_q;

  // The main register reloads whenever it is empty or being drained. The
  // skid entry is older than anything arriving now, so it goes first; while
  // it is occupied in_ready is low and no new beat can be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_valid) begin
        main_q       <= in_payload;
        main_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (in_valid && in_ready) begin
      // Output stalled: park the incoming beat in the skid entry.
      skid_q       <= in_payload;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid = main_valid_q;
  assign out_last  = main_q[PW-1];
  assign out_keep  = main_q[DATA_WIDTH +: KEEP_W];
  assign out_data  = main_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/c2h_stream_arbiter.sv
// ---------------------------------------------------------------------------
// c2h_stream_arbiter
// Packet-granular round-robin arbiter sharing the PCIe C2H AXI-Stream among
// N_SRC application streams. A grant lasts from the first beat to tlast;
// new grants are issued only while link_up is high.
// Ports:
//   clk, sys_rst          PCIe user clock, synchronous active-high reset
//   link_up               gates new grants (an open packet always completes)
//   s_axis_*              N_SRC source streams, source i in slice i
//   m_axis_*              registered output towards S_AXIS_C2H
//   grant_valid           a packet is in progress
//   grant_idx             current (or most recent) granted source
//   pkt_cnt               packets forwarded (tlast handshakes at output), wraps
//   state_dbg             arbiter FSM state (ST_IDLE / ST_XFER)
//
// Handshake: a beat moves on any interface in a cycle where valid and ready
// are both high at the clock edge. valid never waits for ready; once valid
// is high the payload holds until the transfer. Ready may depend on
// registered state only (no combinational path valid->ready).
// ---------------------------------------------------------------------------
module c2h_stream_arbiter
  import c2h_arb_pkg::*;
#(
  parameter  int N_SRC      = DEFAULT_N_SRC,
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int IDX_W      = $clog2(N_SRC),
  localparam int KEEP_W     = DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        sys_rst,
  input  logic                        link_up,
  input  logic [N_SRC-1:0]            s_axis_tvalid,
  output logic [N_SRC-1:0]            s_axis_tready,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_SRC*KEEP_W-1:0]     s_axis_tkeep,
  input  logic [N_SRC-1:0]            s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_W-1:0]           m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        grant_valid,
  output logic [IDX_W-1:0]            grant_idx,
  output logic [31:0]                 pkt_cnt,
  output logic                        state_dbg
);

  logic                  state_q;
  logic                  state_d;
  logic [IDX_W-1:0]      grant_idx_q;
  logic [IDX_W-1:0]      last_ptr_q;
  logic                  grant_valid_q;
  logic [31:0]           pkt_cnt_q;

  logic [MAX_SRC-1:0]    req_vec;
  logic [IDX_W-1:0]      rr_pick;
  logic                  arb_go;

  logic                  slice_in_valid;
  logic                  slice_in_ready;
  logic [DATA_WIDTH-1:0] slice_in_data;
  logic [KEEP_W-1:0]     slice_in_keep;
  logic                  slice_in_last;
  logic                  beat_acc;
  logic                  pkt_end;

  // ---- arbitration --------------------------------------------------------
  always_comb begin
    req_vec              = '0;
    req_vec[N_SRC-1:0]   = s_axis_tvalid;
  end

  assign rr_pick = IDX_W'(rr_next(req_vec, 3'(last_ptr_q), N_SRC));
  assign arb_go  = (state_q == ST_IDLE) && link_up && (|s_axis_tvalid);

  // ---- data path mux (granted source into the output slice) ---------------
  assign slice_in_valid = (state_q == ST_XFER) && s_axis_tvalid[grant_idx_q];
  assign slice_in_data  = s_axis_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign slice_in_keep  = s_axis_tkeep[grant_idx_q*KEEP_W +: KEEP_W];
  assign slice_in_last  = s_axis_tlast[grant_idx_q];
  assign beat_acc       = slice_in_valid && slice_in_ready;
  assign pkt_end        = beat_acc && slice_in_last;

  // ---- FSM: state register ------------------------------------------------
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next state ----------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_go)  state_d = ST_XFER;
      ST_XFER: if (pkt_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs -------------------------------------------------------
  // Only the granted source sees ready, and only while the slice has room.
  // Requests arriving in the tlast cycle are seen in the following IDLE
  // cycle, which gives the one-cycle bubble between packets.
  always_comb begin
    s_axis_tready = '0;
    if (state_q == ST_XFER) begin
      s_axis_tready[grant_idx_q] = slice_in_ready;
    end
  end

  // ---- grant / pointer registers ------------------------------------------
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      last_ptr_q    <= IDX_W'(N_SRC - 1);
    end else if (arb_go) begin
      grant_idx_q   <= rr_pick;
      grant_valid_q <= 1'b1;
    end else if (pkt_end) begin
      last_ptr_q    <= grant_idx_q;
      grant_valid_q <= 1'b0;
    end
  end

  // ---- packet counter (output-side tlast handshakes) ----------------------
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      pkt_cnt_q <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  // ---- output register slice ----------------------------------------------
  axis_reg_slice #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_W     (KEEP_W)
  ) u_out_slice (
    .clk       (clk),
    .rst       (sys_rst),
    .in_valid  (slice_in_valid),
    .in_ready  (slice_in_ready),
    .in_data   (slice_in_data),
    .in_keep   (slice_in_keep),
    .in_last   (slice_in_last),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .out_keep  (m_axis_tkeep),
    .out_last  (m_axis_tlast)
  );

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_c2h_stream_arbiter.sv
module tb_c2h_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int BW = DW + KW + 1;   // packed beat: {last, keep, data}
  localparam int MEM_D = 64;

  // ---- clock / reset -------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              sys_rst;
  logic              link_up;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tready;
  logic [N*DW-1:0]   s_tdata;
  logic [N*KW-1:0]   s_tkeep;
  logic [N-1:0]      s_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [31:0]       pkt_cnt;
  logic              state_dbg;

  c2h_stream_arbiter #(.N_SRC(N), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .sys_rst       (sys_rst),
    .link_up       (link_up),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .pkt_cnt       (pkt_cnt),
    .state_dbg     (state_dbg)
  );

  // ---- bookkeeping ---------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- source packet storage and reference model ---------------------------
  logic [BW-1:0] src_mem [N][MEM_D];
  int            src_head [N];   // driver cursor
  int            src_tail [N];
  int            mdl_head [N];   // model cursor
  int            mdl_last;       // model's round-robin pointer
  int            exp_pkt;        // model packet count
  int            pkt_seq;
  bit            drop_link_on_fire;
  logic [BW-1:0] exp_q[$];

  task automatic add_pkt(input int src, input int len);
    logic [BW-1:0] beat;
    for (int b = 0; b < len; b++) begin
      beat[DW-1:0]       = {8'(src), 8'(pkt_seq), 16'($urandom)};
      beat[DW +: KW]     = 4'($urandom_range(1, 15));
      beat[BW-1]         = (b == len - 1);
      src_mem[src][src_tail[src]] = beat;
      src_tail[src]++;
    end
    pkt_seq++;
  endtask

  // Queue the next whole packet of src into the scoreboard.
  task automatic expect_pkt(input int src);
    logic [BW-1:0] beat;
    do begin
      beat = src_mem[src][mdl_head[src]];
      mdl_head[src]++;
      exp_q.push_back(beat);
    end while (!beat[BW-1]);
    exp_pkt++;
  endtask

  // Packet-level round robin over sources with pending packets: the source
  // after the last one served that still has work goes next.
  task automatic build_expected();
    bit any;
    int pick;
    forever begin
      any = 0;
      pick = 0;
      for (int k = 1; k <= N; k++) begin
        int s;
        s = (mdl_last + k) % N;
        if (!any && mdl_head[s] < src_tail[s]) begin
          any  = 1;
          pick = s;
        end
      end
      if (!any) break;
      expect_pkt(pick);
      mdl_last = pick;
    end
  endtask

  // ---- driver --------------------------------------------------------------
  task automatic present_inputs();
    logic [BW-1:0] beat;
    for (int i = 0; i < N; i++) begin
      if (src_head[i] < src_tail[i]) begin
        beat = src_mem[i][src_head[i]];
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = beat[DW-1:0];
        s_tkeep[i*KW +: KW]  = beat[DW +: KW];
        s_tlast[i]           = beat[BW-1];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tkeep[i*KW +: KW]  = '0;
        s_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    sys_rst  = 1'b1;
    link_up  = 1'b1;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    repeat (2) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
      mdl_head[i] = 0;
    end
    exp_q.delete();
    exp_pkt  = 0;
    mdl_last = N - 1;
  endtask

  // Run until the scoreboard drains or the cycle budget expires.
  task automatic run(input int budget, input bit rnd_ready, input bit check_gap);
    int            cyc;
    int            last_end;
    bit            new_pkt;
    logic [N-1:0]  fire;
    logic          fired_last;
    logic [BW-1:0] got;
    cyc      = 0;
    last_end = -1;
    new_pkt  = 1;
    while (exp_q.size() > 0 && cyc < budget) begin
      present_inputs();
      m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      fire       = s_tvalid & s_tready;
      fired_last = 1'b0;
      if (fire != '0) begin
        check("single_src_fire", 64'($countones(fire)), 64'd1);
        for (int i = 0; i < N; i++) if (fire[i]) fired_last = s_tlast[i];
        if (check_gap && new_pkt && last_end >= 0)
          check("bubble_gap", 64'(cyc - last_end), 64'd2);
        new_pkt = fired_last;
        if (fired_last) last_end = cyc;
      end
      if (m_tvalid && m_tready) begin
        got = {m_tlast, m_tkeep, m_tdata};
        check("out_beat", 64'(got), 64'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (fire[i]) src_head[i]++;
      if (drop_link_on_fire && fire != '0) link_up = 1'b0;
      cyc++;
    end
    if (exp_q.size() != 0) check("run_timeout_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---- table-driven single-cycle arbitration vectors -----------------------
  typedef struct {
    logic       lu;
    logic [3:0] req;
    logic       exp_gv;
    logic [1:0] exp_idx;
    logic [3:0] exp_rdy;
  } vec_t;

  vec_t vecs [7];

  // ---- watchdog ------------------------------------------------------------
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---- main sequence -------------------------------------------------------
  initial begin
    logic [N-1:0] fire;
    int           fires;

    drop_link_on_fire = 0;
    pkt_seq           = 0;
    vecs[0] = '{1'b1, 4'b0001, 1'b1, 2'd0, 4'b0001};
    vecs[1] = '{1'b1, 4'b0110, 1'b1, 2'd1, 4'b0010};
    vecs[2] = '{1'b1, 4'b1000, 1'b1, 2'd3, 4'b1000};
    vecs[3] = '{1'b1, 4'b1100, 1'b1, 2'd2, 4'b0100};
    vecs[4] = '{1'b0, 4'b1111, 1'b0, 2'd0, 4'b0000};
    vecs[5] = '{1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000};
    vecs[6] = '{1'b1, 4'b1010, 1'b1, 2'd1, 4'b0010};

    // Test 1: reset values, then one 3-beat packet from source 0.
    do_reset();
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_grant_valid", 64'(grant_valid), 64'd0);
    check("rst_grant_idx", 64'(grant_idx), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    add_pkt(0, 3);
    build_expected();
    run(40, 0, 0);
    check("t1_grant_idx", 64'(grant_idx), 64'd0);
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // Arbitration vectors: one IDLE cycle from reset (pointer = N-1).
    for (int v = 0; v < 7; v++) begin
      do_reset();
      link_up  = vecs[v].lu;
      s_tvalid = vecs[v].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_grant_valid", v), 64'(grant_valid), 64'(vecs[v].exp_gv));
      check($sformatf("vec%0d_grant_idx", v), 64'(grant_idx), 64'(vecs[v].exp_idx));
      check($sformatf("vec%0d_s_tready", v), 64'(s_tready), 64'(vecs[v].exp_rdy));
      check($sformatf("vec%0d_state", v), 64'(state_dbg), 64'(vecs[v].exp_gv));
    end

    // Test 2: all sources valid, 2 x 2-beat packets each -> 0,1,2,3,0,1,2,3.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++) add_pkt(s, 2);
    build_expected();
    run(200, 0, 0);
    check("t2_pkt_cnt", 64'(pkt_cnt), 64'd8);

    // Test 3: random sources/lengths, random downstream ready.
    do_reset();
    for (int p = 0; p < 12; p++) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 4));
    build_expected();
    run(1000, 1, 0);
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

    // Test 4: link down blocks grants; link drop mid-packet completes it.
    do_reset();
    add_pkt(1, 5);
    add_pkt(2, 2);
    link_up = 1'b0;
    for (int c = 0; c < 6; c++) begin
      present_inputs();
      @(negedge clk);
      check("t4_down_grant_valid", 64'(grant_valid), 64'd0);
      check("t4_down_s_tready", 64'(s_tready), 64'd0);
      @(posedge clk);
      #1;
    end
    link_up = 1'b1;
    expect_pkt(1);
    mdl_last = 1;
    drop_link_on_fire = 1;
    run(100, 1, 0);
    drop_link_on_fire = 0;
    m_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      present_inputs();
      @(negedge clk);
      check("t4_after_grant_valid", 64'(grant_valid), 64'd0);
      check("t4_after_s_tready", 64'(s_tready), 64'd0);
      check("t4_after_m_tvalid", 64'(m_tvalid), 64'd0);
      @(posedge clk);
      #1;
    end
    check("t4_pkt_cnt_mid", 64'(pkt_cnt), 64'd1);
    link_up = 1'b1;
    build_expected();
    run(40, 0, 0);
    check("t4_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // Test 5: only source 2, three packets, one bubble between packets.
    do_reset();
    for (int p = 0; p < 3; p++) add_pkt(2, $urandom_range(1, 4));
    build_expected();
    run(100, 0, 1);
    check("t5_grant_idx", 64'(grant_idx), 64'd2);
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'd3);

    // Test 6: reset on beat 2 of a 4-beat packet, then source 0 wins first.
    do_reset();
    add_pkt(2, 1);
    build_expected();
    run(20, 0, 0);
    add_pkt(3, 4);
    m_tready = 1'b0;
    fires = 0;
    for (int c = 0; c < 20 && fires < 2; c++) begin
      present_inputs();
      @(negedge clk);
      fire = s_tvalid & s_tready;
      if (fire != '0) fires++;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (fire[i]) src_head[i]++;
    end
    check("t6_beats_before_rst", 64'(fires), 64'd2);
    check("t6_m_tvalid_before", 64'(m_tvalid), 64'd1);
    sys_rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_grant_valid", 64'(grant_valid), 64'd0);
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("t6_s_tready", 64'(s_tready), 64'd0);
    do_reset();
    add_pkt(3, 2);
    add_pkt(1, 1);
    add_pkt(0, 1);
    build_expected();
    run(60, 0, 0);
    check("t6_pkt_cnt_after", 64'(pkt_cnt), 64'd3);
    check("t6_last_grant", 64'(grant_idx), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
